// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared definitions for the iterative AES-128 decryptor.
//   - NB: number of 32-bit columns in the AES state
//   - SBOX / INV_SBOX: forward S-box (key schedule) and inverse S-box (rounds),
//     stored as packed tables with entry 0 in the MSBs
//   - RCON: key-schedule round constants for rounds 1..10, round 1 in the MSBs
//   - state_e: controller states
//   - sbox, inv_sbox, rcon, xtime, gmul: table lookups and GF(2^8) helpers
package aes128_decrypt_iter_pkg;

    localparam int NB = 4;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    // i is the key-schedule round, 1..10
    function automatic logic [7:0] rcon(input int i);
        return RCON[(10 - i) * 8 +: 8];
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply in GF(2^8)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes128_decrypt_iter_key_expand.sv
// aes_key_expand: purely combinational AES-128 key schedule.
//   key    : 128-bit cipher key, byte 0 in the MSBs
//   rk_bus : 11 round keys; rk0 (the cipher key) in [1407:1280],
//            rk10 in [127:0]
module aes_key_expand
    import aes128_decrypt_iter_pkg::*;
(
    input  logic [127:0]  key,
    output logic [1407:0] rk_bus
);

    logic [31:0] w [44];

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Whole expansion in one process so the word chain is a plain
    // combinational cascade rather than 44 cross-coupled assigns.
    always_comb begin
        logic [31:0] t;
        t = 32'h0;
        for (int i = 0; i < 4; i++) begin
            w[i] = key[127 - 32 * i -: 32];
        end
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / 4), 24'h0};
            end
            w[i] = w[i - 4] ^ t;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_rk
            assign rk_bus[1407 - 128 * gi -: 128] =
                {w[4 * gi], w[4 * gi + 1], w[4 * gi + 2], w[4 * gi + 3]};
        end
    endgenerate

endmodule

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one round per clock.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : launch request, accepted only while idle
//   data_in  : 128-bit ciphertext, byte 0 in [127:120]
//   key      : cipher key, byte 0 in the MSBs (AES-128 only)
//   data_out : state register; plaintext once done has pulsed
//   busy     : high while a block is being decrypted
//   done     : one-cycle pulse when data_out holds the final plaintext
// Only NK=4 / NR=10 is supported.
module aes128_decrypt_iter
    import aes128_decrypt_iter_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [127:0]    data_in,
    input  logic [NK*32-1:0] key,
    output logic [127:0]    data_out,
    output logic            busy,
    output logic            done
);

    state_e        fsm_q,   fsm_d;
    logic [3:0]    round_q, round_d;
    logic [127:0]  key_q,   key_d;
    logic [127:0]  blk_q,   blk_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [127:0]  expand_key;
    logic [1407:0] rk_bus;
    logic [127:0]  rk_round;
    logic [127:0]  round_st;

    // While idle the schedule follows the key port so rk10 is available for
    // the launch edge; once running it is driven only by the latched key.
    assign expand_key = busy_q ? key_q : key[127:0];

    aes_key_expand u_key_expand (
        .key    (expand_key),
        .rk_bus (rk_bus)
    );

    // round_q counts 9..1 for the full rounds and reaches 0 for the final
    // round, which conveniently selects rk0.
    assign rk_round = rk_bus[128 * (NR - int'(round_q)) +: 128];

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
        return s[127 - 8 * n -: 8];
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = get_byte(s, r + 4 * ((c - r + 4) % 4));
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127 - 8 * n -: 8] = inv_sbox(get_byte(s, n));
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = get_byte(s, 4 * c);
            a1 = get_byte(s, 4 * c + 1);
            a2 = get_byte(s, 4 * c + 2);
            a3 = get_byte(s, 4 * c + 3);
            o[127 - 32 * c -: 8]      = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[127 - 32 * c - 8 -: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[127 - 32 * c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[127 - 32 * c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Common part of full and final rounds; InvMixColumns is added after
    // AddRoundKey for rounds 9..1 only.
    assign round_st = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_round;

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        key_d   = key_q;
        blk_d   = blk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key[127:0];
                    blk_d   = data_in ^ rk_bus[127:0];
                    round_d = 4'(NR - 1);
                    busy_d  = 1'b1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (round_q != 4'd0) begin
                    blk_d   = inv_mix_columns(round_st);
                    round_d = round_q - 4'd1;
                end else begin
                    blk_d  = round_st;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = ST_IDLE;
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            key_q   <= '0;
            blk_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = blk_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench for aes128_decrypt_iter using known-answer vectors.
// Expected plaintexts are queued when a block is launched and popped when
// the DUT raises done.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key = '0;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    logic [127:0] exp_q [$];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_decrypt_iter #(.NK(4), .NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .key      (key),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance negedges until done is seen or the limit expires.
    task automatic wait_done(input int limit, output bit seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (n < limit && !seen) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, done); end
        $display("txn reset: data_out=%h busy=%b done=%b", data_out, busy, done);
    endtask

    task automatic test_single_block(input string name, input logic [127:0] k,
                                     input logic [127:0] ct, input logic [127:0] pt);
        int t0;
        bit seen;
        logic [127:0] exp;
        @(negedge clk);
        key = k; data_in = ct; start = 1'b1;
        exp_q.push_back(pt);
        t0 = cyc_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", name, busy); end
        wait_done(30, seen);
        total++;
        if (!seen || (cyc_cnt - t0) != 10) begin
            bad++; $display("FAIL %s_latency: seen=%0d got %0d cycles want 10", name, seen, cyc_cnt - t0);
        end
        if (seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL %s_scoreboard: got empty queue want entry", name);
            end else begin
                exp = exp_q.pop_front();
                total++; if (data_out !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", name, data_out, exp); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_fall: got %b want 0", name, busy); end
                $display("txn %s: key=%h ct=%h pt=%h", name, k, ct, data_out);
                @(negedge clk);
                total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_width: got %b want 0", name, done); end
                total++; if (data_out !== exp) begin bad++; $display("FAIL %s_hold: got %h want %h", name, data_out, exp); end
            end
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic test_key_isolation();
        int t0;
        bit seen;
        logic [127:0] exp;
        @(negedge clk);
        key = '0; data_in = C0; start = 1'b1;
        exp_q.push_back(128'h0);
        t0 = cyc_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        data_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;   // repeated start while busy must be ignored
        key = K2; data_in = C2;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(30, seen);
        total++;
        if (!seen || (cyc_cnt - t0) != 10) begin
            bad++; $display("FAIL iso_latency: seen=%0d got %0d cycles want 10", seen, cyc_cnt - t0);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL iso_scoreboard: got empty queue want entry");
        end else begin
            exp = exp_q.pop_front();
            total++; if (data_out !== exp) begin bad++; $display("FAIL iso_data: got %h want %h", data_out, exp); end
        end
        $display("txn isolation: key=0 ct=%h pt=%h", C0, data_out);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            key = {$urandom, $urandom, $urandom, $urandom};
            data_in = {$urandom, $urandom, $urandom, $urandom};
        end
        total++; if (data_out !== 128'h0 || busy !== 1'b0) begin bad++; $display("FAIL iso_hold: got %h busy=%b want 0 busy=0", data_out, busy); end
    endtask

    task automatic test_back_to_back();
        int d1;
        bit seen;
        logic [127:0] exp;
        @(negedge clk);
        key = K1; data_in = C1; start = 1'b1;
        exp_q.push_back(P1);
        @(negedge clk);
        key = K2; data_in = C2;          // start stays high
        exp_q.push_back(P2);
        wait_done(30, seen);
        d1 = cyc_cnt;
        total++;
        if (!seen || exp_q.size() == 0) begin
            bad++; $display("FAIL b2b_first: seen=%0d queue=%0d want done and entry", seen, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            total++; if (data_out !== exp) begin bad++; $display("FAIL b2b_data1: got %h want %h", data_out, exp); end
            $display("txn b2b_1: pt=%h", data_out);
        end
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        wait_done(30, seen);
        total++;
        if (!seen || (cyc_cnt - d1) != 11) begin
            bad++; $display("FAIL b2b_gap: seen=%0d got %0d cycles want 11", seen, cyc_cnt - d1);
        end
        total++;
        if (!seen || exp_q.size() == 0) begin
            bad++; $display("FAIL b2b_second: seen=%0d queue=%0d want done and entry", seen, exp_q.size());
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            total++; if (data_out !== exp) begin bad++; $display("FAIL b2b_data2: got %h want %h", data_out, exp); end
            $display("txn b2b_2: pt=%h", data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int hits;
        @(negedge clk);
        key = K1; data_in = C1; start = 1'b1;
        exp_q.push_back(P1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();   // aborted block produces nothing
        total++; if (data_out !== 128'h0) begin bad++; $display("FAIL midrst_data: got %h want 0", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 1'b0) hits++;
        end
        total++; if (hits != 0) begin bad++; $display("FAIL midrst_no_done: got %0d done cycles want 0", hits); end
        total++; if (data_out !== 128'h0) begin bad++; $display("FAIL midrst_idle_data: got %h want 0", data_out); end
        $display("txn mid_reset: data_out=%h busy=%b", data_out, busy);
    endtask

    initial begin
        test_reset();
        test_single_block("fips_c1", K1, C1, P1);
        test_single_block("fips_b", K2, C2, P2);
        test_key_isolation();
        test_back_to_back();
        test_mid_reset();
        test_single_block("after_reset", K1, C1, P1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_iter.md
AES128_DECRYPT_ITER -- requirements
Module: aes128_decrypt_iter

Interface
REQ-001 Parameters: NK, default 4, key length in 32-bit words; NR, default 10, round count; only NK=4/NR=10 (AES-128) SHALL be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled high while idle launches a decryption.
REQ-005 data_in  input  128  ciphertext block, byte 0 in bits [127:120] (FIPS-197 column-major state order).
REQ-006 key  input  NK*32  cipher key, byte 0 in the MSBs.
REQ-007 data_out  output  128  state register; holds the plaintext after done.
REQ-008 busy  output  1  high while a decryption is in progress.
REQ-009 done  output  1  one-cycle pulse marking data_out as final plaintext.

Function
REQ-010 The block SHALL implement FIPS-197 AES-128 inverse cipher: initial AddRoundKey(rk10), rounds 9..1 each InvShiftRows, InvSubBytes, AddRoundKey(rk_r), InvMixColumns, final round InvShiftRows, InvSubBytes, AddRoundKey(rk0).
REQ-011 Key schedule: rk0 = cipher key; rk1..rk10 per FIPS-197 KeyExpansion (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
REQ-012 On an edge with start=1 and busy=0, key SHALL be latched into an internal key register and state SHALL load data_in XOR rk10 (cycle T0); busy SHALL go high.
REQ-013 Round keys SHALL be derived combinationally from the latched key register only; changes on key/data_in after T0 SHALL NOT affect the operation.
REQ-014 Edges T1..T9 SHALL apply rounds 9..1 in order, using a 4-bit round counter counting down from 9.
REQ-015 Edge T10 SHALL apply the final round; at that edge busy SHALL fall and done SHALL rise for exactly one cycle; latency start-to-done = 10 cycles.
REQ-016 start while busy=1 SHALL be ignored; no queuing.
REQ-017 start in the same cycle done is high SHALL be accepted (busy=0 then), giving back-to-back throughput of one block per 11 cycles.
REQ-018 data_out SHALL hold the plaintext unchanged after done until the next accepted start; intermediate round states are visible on data_out while busy.
REQ-019 InvMixColumns SHALL use GF(2^8) multiplication by 0e,0b,0d,09 with reduction polynomial 0x11b.

Reset
REQ-020 rst_n low SHALL asynchronously clear data_out to 0, busy to 0, done to 0, round counter to 0, key register to 0.
REQ-021 Reset asserted mid-operation SHALL abort the decryption; no done pulse SHALL follow; first start after rst_n release SHALL behave as from power-up.

Structure
REQ-022 A shared package SHALL hold the forward S-box (for key schedule), the inverse S-box, the Rcon table, NB=4 constant, and GF helper functions (xtime, gmul).
REQ-023 Key expansion SHALL be a single sub-module aes_key_expand (128-bit key in, 11x128-bit round-key bus out, rk0 in the MSB slice); AddRoundKey and round transforms SHALL remain inline functions.

Verification
REQ-024 key=000102030405060708090a0b0c0d0e0f, data_in=69c4e0d86a7b0430d8cdb78070b4c55a, start -> done 10 cycles later, data_out=00112233445566778899aabbccddeeff.
REQ-025 key=2b7e151628aed2a6abf7158809cf4f3c, data_in=3925841d02dc09fbdc118597196a0b32 -> data_out=3243f6a8885a308d313198a2e0370734.
REQ-026 key=0, data_in=66e94bd4ef8a2c3b884cfa59ca342b2e -> data_out=0; then key/data_in changed during busy and start repulsed -> no effect, result still 0.
REQ-027 Back-to-back: start held high with REQ-024 then REQ-025 vectors -> two done pulses 11 cycles apart, each with correct plaintext.
REQ-028 rst_n pulsed low at T5 of a decryption -> data_out=0, busy=0 immediately, no done; subsequent REQ-024 run yields correct plaintext.
